// File: rtl/en_de_pkg.sv
// Shared types and helpers for the serial encode/decode engine.
package en_de_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    function automatic int cw(input int data_size, input int scale_factor);
        return data_size + scale_factor;
    endfunction

endpackage

// File: rtl/en_de_serial_engine_if.sv
// Request/result handshake bundle between a source/sink and the engine.
interface en_de_serial_engine_if #(
    parameter int DATA_SIZE    = 16,
    parameter int POLY_SIZE    = 16,
    parameter int SCALE_FACTOR = 2
);
    import en_de_pkg::*;

    localparam int CW = cw(DATA_SIZE, SCALE_FACTOR);
    localparam int TW = CW * POLY_SIZE;

    logic                 in_valid;
    logic                 in_ready;
    logic                 mode;
    logic [DATA_SIZE-1:0] data_in;
    logic [TW-1:0]        code_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [TW-1:0]        encoded_data;
    logic [DATA_SIZE-1:0] data_out;
    logic                 err;

    modport master (
        output in_valid, mode, data_in, code_in, out_ready,
        input  in_ready, out_valid, encoded_data, data_out, err
    );

    modport slave (
        input  in_valid, mode, data_in, code_in, out_ready,
        output in_ready, out_valid, encoded_data, data_out, err
    );

endinterface

// File: rtl/en_de_coeff_unit.sv
// One coefficient per cycle: encode value or decode consistency check.
module en_de_coeff_unit
    import en_de_pkg::*;
#(
    parameter int CW           = 18,
    parameter int SCALE_FACTOR = 2
) (
    input  logic          mode_i,
    input  logic          first_i,
    input  logic [CW-1:0] base_i,
    input  logic [CW-1:0] code0_i,
    input  logic [CW-1:0] off_i,
    input  logic [CW-1:0] codei_i,
    output logic [CW-1:0] coeff_o,
    output logic          mismatch_o
);

    logic [CW-1:0] ref_v;
    logic          low_bad;

    // Decoded data must have been shifted: its low bits are always zero.
    if (SCALE_FACTOR > 0) begin : g_low
        assign low_bad = |code0_i[SCALE_FACTOR-1:0];
    end else begin : g_nolow
        assign low_bad = 1'b0;
    end

    always_comb begin
        ref_v      = ((mode_i == MODE_ENC) ? base_i : code0_i) + off_i;
        coeff_o    = (mode_i == MODE_ENC) ? ref_v : codei_i;
        mismatch_o = (mode_i == MODE_DEC)
                   && ((codei_i != ref_v) || (first_i && low_bad));
    end

endmodule

// File: rtl/en_de_serial_engine.sv
// Sequenced encoder/decoder: one coefficient per cycle, valid/ready on both sides.
module en_de_serial_engine
    import en_de_pkg::*;
#(
    parameter int DATA_SIZE    = 16,
    parameter int POLY_SIZE    = 16,
    parameter int SCALE_FACTOR = 2,
    parameter int KEY          = 499
) (
    input logic                  clk,
    input logic                  reset,
    en_de_serial_engine_if.slave bus
);

    localparam int CW = cw(DATA_SIZE, SCALE_FACTOR);
    localparam int TW = CW * POLY_SIZE;
    localparam int IW = $clog2(POLY_SIZE);

    localparam logic [CW-1:0] KEY_C = CW'(KEY);
    localparam logic [IW-1:0] LAST  = IW'(POLY_SIZE - 1);

    state_e               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [CW-1:0]        off_q, off_d;
    logic                 mode_q, mode_d;
    logic [DATA_SIZE-1:0] din_q, din_d;
    logic [TW-1:0]        code_q, code_d;
    logic [TW-1:0]        enc_q, enc_d;
    logic [DATA_SIZE-1:0] dout_q, dout_d;
    logic                 acc_q, acc_d;
    logic                 err_q, err_d;

    logic          accept;
    logic [CW-1:0] base;
    logic [CW-1:0] code0;
    logic [CW-1:0] codei;
    logic [CW-1:0] coeff;
    logic          mism;

    assign bus.in_ready     = reset && (state_q == IDLE);
    assign bus.out_valid    = (state_q == DONE);
    assign bus.encoded_data = enc_q;
    assign bus.data_out     = dout_q;
    assign bus.err          = err_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign base   = CW'(din_q) << SCALE_FACTOR;
    assign code0  = code_q[CW-1:0];
    assign codei  = code_q[int'(idx_q)*CW +: CW];

    en_de_coeff_unit #(
        .CW           (CW),
        .SCALE_FACTOR (SCALE_FACTOR)
    ) u_coeff (
        .mode_i     (mode_q),
        .first_i    (idx_q == '0),
        .base_i     (base),
        .code0_i    (code0),
        .off_i      (off_q),
        .codei_i    (codei),
        .coeff_o    (coeff),
        .mismatch_o (mism)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        off_d   = off_q;
        mode_d  = mode_q;
        din_d   = din_q;
        code_d  = code_q;
        enc_d   = enc_q;
        dout_d  = dout_q;
        acc_d   = acc_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    mode_d  = bus.mode;
                    din_d   = bus.data_in;
                    code_d  = bus.code_in;
                    idx_d   = '0;
                    off_d   = '0;
                    acc_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                enc_d[int'(idx_q)*CW +: CW] = coeff;
                acc_d = acc_q || mism;
                off_d = off_q + KEY_C;
                idx_d = idx_q + 1'b1;
                if (idx_q == '0) begin
                    dout_d = (mode_q == MODE_DEC)
                           ? code0[CW-1:SCALE_FACTOR] : din_q;
                end
                // Publish the accumulated check only once all slots are seen.
                if (idx_q == LAST) begin
                    err_d   = acc_q || mism;
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            off_q   <= '0;
            mode_q  <= MODE_ENC;
            din_q   <= '0;
            code_q  <= '0;
            enc_q   <= '0;
            dout_q  <= '0;
            acc_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            off_q   <= off_d;
            mode_q  <= mode_d;
            din_q   <= din_d;
            code_q  <= code_d;
            enc_q   <= enc_d;
            dout_q  <= dout_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: doc/en_de_serial_engine.md
Name: en_de_serial_engine

Overview:
- Parametrised successor to the single-shot encoder/decoder top: one engine handles both ENCODE and DECODE, selected per transaction.
- Processes one polynomial coefficient per cycle under a sequencer FSM, with valid/ready handshakes on input and output.
- Decode adds a consistency check across all coefficients, with an error flag.
- Sits between the data source and the channel/storage interface.

Parameters:
- DATA_SIZE, 16, width of plaintext data.
- POLY_SIZE, 16, number of coefficients per codeword (>=2).
- SCALE_FACTOR, 2, left-shift applied to data; coefficient width CW = DATA_SIZE+SCALE_FACTOR.
- KEY, 499, per-index coefficient offset, taken mod 2^CW.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  engine can accept a request.
- mode  in  1  0 = ENCODE, 1 = DECODE; sampled at accept.
- data_in  in  DATA_SIZE  plaintext for ENCODE.
- code_in  in  CW*POLY_SIZE  codeword for DECODE; coeff i at bits [i*CW +: CW].
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- encoded_data  out  CW*POLY_SIZE  codeword result (ENCODE) or latched code_in (DECODE).
- data_out  out  DATA_SIZE  decoded data (DECODE) or latched data_in (ENCODE).
- err  out  1  DECODE consistency failure; always 0 after ENCODE.

Behaviour:
- Reset (reset=0, async): state IDLE, idx=0; in_ready=0 while reset is asserted; out_valid=0, encoded_data=0, data_out=0, err=0. Asserting reset mid-RUN or in DONE aborts the transaction with no output.
- FSM states:
  - IDLE: in_ready=1. An accept is in_valid&in_ready on a rising edge. On accept, latch mode, data_in and code_in; idx=0; err_acc=0; go to RUN.
  - RUN: in_ready=0. Each cycle processes coefficient idx; idx increments. After idx=POLY_SIZE-1 is processed, go to DONE.
  - DONE: out_valid=1. Outputs are stable while out_ready=0. On out_valid&out_ready, go to IDLE and drop out_valid on the same edge.
- Latency: accept on edge T, out_valid visible after edge T+POLY_SIZE. Minimum throughput is one transaction per POLY_SIZE+2 cycles.
- ENCODE: base = data<<SCALE_FACTOR. coeff[i] = (base + KEY*i) mod 2^CW, written into encoded_data slot i during RUN. All arithmetic wraps mod 2^CW; there is no saturation. data_out = latched data_in; err = 0.
- DECODE:
  - data_out = code[0][CW-1:SCALE_FACTOR].
  - err_acc |= (code[0][SCALE_FACTOR-1:0] != 0) at idx 0.
  - For i>=1, err_acc |= (code[i] != (code[0] + KEY*i) mod 2^CW).
  - err = err_acc at DONE. encoded_data = latched code_in.
- encoded_data, data_out and err update only during RUN and at the RUN->DONE transition. Values from the previous transaction hold in IDLE.
- in_valid during RUN or DONE is ignored; no request is lost because in_ready=0.
- KEY*i: compute an incremental running offset, offset += KEY each cycle. No multiplier.

Decomposition:
- Shared package en_de_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - mode constants MODE_ENC=0, MODE_DEC=1
  - function cw(DATA_SIZE, SCALE_FACTOR)
- Sub-module en_de_coeff_unit: combinational, one coefficient per cycle. Inputs: mode, base/code0, running offset, code_i. Outputs: coeff_out and mismatch bit.
- The FSM, idx/offset counters and output registers live in the top.

Test Plan:
(All cases use DATA_SIZE=16, POLY_SIZE=4, SCALE_FACTOR=2, KEY=499, CW=18.)
- Reset mid-RUN: assert reset two cycles after an accept -> outputs immediately return to reset values; engine returns to IDLE; in_ready=1 after release.
- ENCODE data_in=5 -> coeffs {20, 519, 1018, 1517}; data_out=5; err=0; out_valid exactly 4 edges after accept.
- ENCODE data_in=65535 (wrap) -> coeffs {262140, 495, 994, 1493}; err=0.
- DECODE code {20, 519, 1018, 1517} -> data_out=5, err=0.
- DECODE with coeff2 corrupted to 1019 -> data_out=5, err=1. Separately, coeff0=21 -> data_out=5, err=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, a new in_valid is ignored. Release out_ready -> one handshake, then IDLE. Back-to-back requests then complete in order with correct results.
